// File: rtl/truth_table_sweeper.sv
// Sweeps every N-bit input code into a small combinational block, holds each for SETTLE cycles,
// samples y once per code and compares the measured truth table against a latched expected table.
module truth_table_sweeper #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [(1<<N)-1:0]   expected,
  input  logic                y_in,
  output logic [N-1:0]        data_out,
  output logic                busy,
  output logic                done,
  output logic [(1<<N)-1:0]   table_out,
  output logic                mismatch,
  output logic [N:0]          err_cnt
);

  localparam int T  = 1 << N;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    code_q,  code_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [T-1:0]    exp_q,   exp_d;
  logic [T-1:0]    tab_q,   tab_d;
  logic [N:0]      err_q,   err_d;
  logic            mm_q,    mm_d;
  logic            last_code;

  assign last_code = (code_q == {N{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tab_q   <= '0;
      err_q   <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tab_q   <= tab_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tab_d   = tab_q;
    err_d   = err_q;
    mm_d    = mm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          exp_d   = expected;
          tab_d   = '0;
          err_d   = '0;
          mm_d    = 1'b0;
          code_d  = '0;
          cnt_d   = SETTLE_M1;
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          tab_d[code_q] = y_in;
          if (y_in != exp_q[code_q]) err_d = err_q + (N+1)'(1);
          if (last_code) begin
            state_d = DONE;
            code_d  = '0;
            // final compare must include the sample taken on this edge
            mm_d    = (tab_d != exp_q);
          end else begin
            code_d = code_q + N'(1);
            cnt_d  = SETTLE_M1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_out  = code_q;
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    table_out = tab_q;
    mismatch  = mm_q;
    err_cnt   = err_q;
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a SETTLE=1 sweeper on a combinational majority gate and a SETTLE=3 sweeper
// on a majority gate with two cycles of output delay.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start1, y1, busy1, done1, mm1;
  logic [7:0] exp1, tab1;
  logic [2:0] dout1;
  logic [3:0] err1;

  logic       start3, y3, busy3, done3, mm3;
  logic [7:0] exp3, tab3;
  logic [2:0] dout3;
  logic [3:0] err3;
  logic       yd1, yd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  assign y1 = maj(dout1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yd1 <= 1'b0;
      yd2 <= 1'b0;
    end else begin
      yd1 <= maj(dout3);
      yd2 <= yd1;
    end
  end
  assign y3 = yd2;

  truth_table_sweeper #(.N(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .y_in(y1),
    .data_out(dout1), .busy(busy1), .done(done1), .table_out(tab1),
    .mismatch(mm1), .err_cnt(err1)
  );

  truth_table_sweeper #(.N(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .y_in(y3),
    .data_out(dout3), .busy(busy3), .done(done3), .table_out(tab3),
    .mismatch(mm3), .err_cnt(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full SETTLE=1 sweep on dut1; returns one edge after done (back in IDLE).
  task automatic sweep1(input logic [7:0] exp_v, input logic corrupt, input logic poke,
                        input logic [7:0] want_tab, input logic [3:0] want_err,
                        input logic want_mm);
    exp1   = exp_v;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("start_busy", 32'(busy1), 32'd1);
    check("start_tab_clear", 32'(tab1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("code_step", 32'(dout1), 32'(i));
      check("no_early_done", 32'(done1), 32'd0);
      if (poke && i == 3) start1 = 1'b1;
      if (poke && i == 4) start1 = 1'b0;
      if (corrupt && i == 4) exp1 = 8'h00;
      tick();
    end
    check("done_pulse", 32'(done1), 32'd1);
    check("done_busy_low", 32'(busy1), 32'd0);
    check("done_code_zero", 32'(dout1), 32'd0);
    check("table", 32'(tab1), 32'(want_tab));
    check("err_cnt", 32'(err1), 32'(want_err));
    check("mismatch", 32'(mm1), 32'(want_mm));
    tick();
    check("done_one_cycle", 32'(done1), 32'd0);
    check("idle_table_hold", 32'(tab1), 32'(want_tab));
    check("idle_err_hold", 32'(err1), 32'(want_err));
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b1;
    start3 = 1'b1;
    exp1   = 8'hFF;
    exp3   = 8'hFF;
    repeat (3) tick();
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_code", 32'(dout1), 32'd0);
    check("rst_table", 32'(tab1), 32'd0);
    check("rst_mm", 32'(mm1), 32'd0);
    check("rst_err", 32'(err1), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    start1 = 1'b0;
    start3 = 1'b0;
    rst_n  = 1'b1;
    tick();
    check("idle_no_start", 32'(busy1), 32'd0);

    // majority, correct expectation
    sweep1(8'hE8, 1'b0, 1'b0, 8'hE8, 4'd0, 1'b0);
    // one wrong expected bit, expected corrupted mid-sweep
    sweep1(8'hE9, 1'b1, 1'b0, 8'hE8, 4'd1, 1'b1);
    // every bit wrong: error count reaches 2^N
    sweep1(8'h17, 1'b0, 1'b0, 8'hE8, 4'd8, 1'b1);
    // stray start pulse while sweeping
    sweep1(8'hE8, 1'b0, 1'b1, 8'hE8, 4'd0, 1'b0);

    // SETTLE=3 with delayed y
    exp3   = 8'hE8;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        check("s3_code_hold", 32'(dout3), 32'(c));
        check("s3_busy", 32'(busy3), 32'd1);
        tick();
      end
    end
    check("s3_done", 32'(done3), 32'd1);
    check("s3_table", 32'(tab3), 32'hE8);
    check("s3_err", 32'(err3), 32'd0);
    check("s3_mm", 32'(mm3), 32'd0);
    tick();
    check("s3_done_clear", 32'(done3), 32'd0);

    // asynchronous reset mid-sweep
    exp1   = 8'hE8;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    check("pre_rst_code", 32'(dout1), 32'd4);
    check("pre_rst_table", 32'(tab1), 32'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy1), 32'd0);
    check("arst_code", 32'(dout1), 32'd0);
    check("arst_table", 32'(tab1), 32'd0);
    check("arst_err", 32'(err1), 32'd0);
    check("arst_table3", 32'(tab3), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    sweep1(8'hE8, 1'b0, 1'b0, 8'hE8, 4'd0, 1'b0);

    // start held high: restart on the second edge after done rises
    exp1   = 8'hE8;
    start1 = 1'b1;
    tick();
    repeat (8) tick();
    check("hold_done", 32'(done1), 32'd1);
    check("hold_table_done", 32'(tab1), 32'hE8);
    tick();
    check("hold_idle_gap", 32'(busy1), 32'd0);
    check("hold_idle_table", 32'(tab1), 32'hE8);
    tick();
    check("hold_restart_busy", 32'(busy1), 32'd1);
    check("hold_restart_clear", 32'(tab1), 32'd0);
    start1 = 1'b0;
    repeat (8) tick();
    check("hold_second_done", 32'(done1), 32'd1);
    check("hold_second_table", 32'(tab1), 32'hE8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
